// File: rtl/decode_pkg.sv
// decode_pkg: MIPS opcode/funct encodings, ALU op codes, field widths and the control bundle type
package decode_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] F_JR     = 6'h08;
  localparam logic [5:0] F_ADD    = 6'h20;
  localparam logic [5:0] F_ADDU   = 6'h21;
  localparam logic [5:0] F_SUB    = 6'h22;
  localparam logic [5:0] F_XOR    = 6'h26;
  localparam logic [5:0] F_SLT    = 6'h2A;
  localparam int ALU_W   = 3;
  localparam int RF_W    = 5;
  localparam int IMM16_W = 16;
  localparam int IMM26_W = 26;
  localparam int CNT_W   = 16;
  localparam logic [ALU_W-1:0] ALU_ADD = 3'd0;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'd1;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'd2;
  localparam logic [ALU_W-1:0] ALU_XOR = 3'd3;
  localparam logic [ALU_W-1:0] ALU_BNE = 3'd4;
  localparam logic [RF_W-1:0] LINK_REG = 5'd31;
  typedef struct packed {
    logic reg_wr, pc_wr, mem_to_reg, alu_src, dm_wr, reg_dst, pc_src, link, illegal;
    logic [ALU_W-1:0] alu_op;
    logic [RF_W-1:0] rs, rt, wr_reg;
    logic [IMM16_W-1:0] imm16;
    logic [IMM26_W-1:0] imm26;
  } ctrl_t;
  // instruction classes whose rt field is a source operand
  function automatic logic reads_rt(input logic [5:0] op);
    return op == OP_RTYPE || op == OP_SW || op == OP_BEQ || op == OP_BNE;
  endfunction
endpackage

// File: rtl/decode_fifo.sv
// decode_fifo: DEPTH-entry instruction buffer with wrap-bit pointers and synchronous flush
// ports: clk, rst_n (async low), flush, push/din, pop/dout, empty, full
module decode_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (push && !full && !flush) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/decode_stage.sv
// decode_stage: buffers fetched MIPS words and decodes the FIFO head into a registered control bundle
// ports: fetch side in_valid/in_ready/instruction, flush, downstream out_valid/out_ready,
//        decoded control flags, alu_op, rs/rt/wr_reg, imm16/imm26, illegal, stall_cnt
module decode_stage
  import decode_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int REG_W = 5,
  parameter int HAZARD_EN = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        instruction,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               reg_wr,
  output logic               pc_wr,
  output logic               mem_to_reg,
  output logic               alu_src,
  output logic               dm_wr,
  output logic               reg_dst,
  output logic               pc_src,
  output logic               link,
  output logic [ALU_W-1:0]   alu_op,
  output logic [REG_W-1:0]   rs,
  output logic [REG_W-1:0]   rt,
  output logic [REG_W-1:0]   wr_reg,
  output logic [IMM16_W-1:0] imm16,
  output logic [IMM26_W-1:0] imm26,
  output logic               illegal,
  output logic [CNT_W-1:0]   stall_cnt
);
  logic [31:0] head;
  logic empty, full, pop, hazard;
  ctrl_t cur, nxt;
  function automatic ctrl_t decode(input logic [31:0] i);
    ctrl_t c;
    c = '0;
    case (i[31:26])
      OP_RTYPE: begin
        c.rs = i[25:21];
        c.rt = i[20:16];
        case (i[5:0])
          F_ADD, F_ADDU, F_SUB, F_SLT, F_XOR: begin
            c.reg_wr = 1'b1;
            c.wr_reg = i[15:11];
            c.alu_op = i[5:0] == F_SUB ? ALU_SUB : i[5:0] == F_SLT ? ALU_SLT :
                       i[5:0] == F_XOR ? ALU_XOR : ALU_ADD;
          end
          F_JR: begin
            c.pc_wr = 1'b1;
            c.rt = '0;
          end
          default: begin
            c = '0;
            c.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_XORI: begin
        c.alu_src = 1'b1;
        c.reg_dst = 1'b1;
        c.reg_wr = 1'b1;
        c.rs = i[25:21];
        c.wr_reg = i[20:16];
        c.imm16 = i[15:0];
        c.alu_op = i[31:26] == OP_XORI ? ALU_XOR : ALU_ADD;
      end
      OP_LW: begin
        c.alu_src = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_wr = 1'b1;
        c.rs = i[25:21];
        c.wr_reg = i[20:16];
        c.imm16 = i[15:0];
      end
      OP_SW: begin
        c.alu_src = 1'b1;
        c.dm_wr = 1'b1;
        c.rs = i[25:21];
        c.rt = i[20:16];
        c.imm16 = i[15:0];
      end
      OP_BEQ, OP_BNE: begin
        c.pc_src = 1'b1;
        c.rs = i[25:21];
        c.rt = i[20:16];
        c.imm16 = i[15:0];
        c.alu_op = i[31:26] == OP_BNE ? ALU_BNE : ALU_SUB;
      end
      OP_J, OP_JAL: begin
        c.pc_src = 1'b1;
        c.imm26 = i[25:0];
        c.link = i[31:26] == OP_JAL;
        c.reg_wr = i[31:26] == OP_JAL;
        c.wr_reg = i[31:26] == OP_JAL ? LINK_REG : '0;
      end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction
  decode_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .push(in_valid && in_ready), .pop(pop), .din(instruction),
    .dout(head), .empty(empty), .full(full)
  );
  assign in_ready = !full;
  assign nxt = decode(head);
  // only a lw leaving the output register this cycle can starve the head of its operand
  assign hazard = HAZARD_EN != 0 && out_valid && out_ready && cur.mem_to_reg && cur.wr_reg != '0 && !empty &&
                  (head[25:21] == cur.wr_reg || (reads_rt(head[31:26]) && head[20:16] == cur.wr_reg));
  assign pop = !empty && (!out_valid || out_ready) && !hazard && !flush;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      cur <= '0;
      stall_cnt <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
        cur <= '0;
      end else if (pop) begin
        out_valid <= 1'b1;
        cur <= nxt;
      end else if (out_ready || !out_valid) begin
        out_valid <= 1'b0;
        cur <= '0;
      end
      if (hazard && !flush && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  assign reg_wr = cur.reg_wr;
  assign pc_wr = cur.pc_wr;
  assign mem_to_reg = cur.mem_to_reg;
  assign alu_src = cur.alu_src;
  assign dm_wr = cur.dm_wr;
  assign reg_dst = cur.reg_dst;
  assign pc_src = cur.pc_src;
  assign link = cur.link;
  assign illegal = cur.illegal;
  assign alu_op = cur.alu_op;
  assign rs = REG_W'(cur.rs);
  assign rt = REG_W'(cur.rt);
  assign wr_reg = REG_W'(cur.wr_reg);
  assign imm16 = cur.imm16;
  assign imm26 = cur.imm26;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scoreboard bench for decode_stage
module tb_decode_stage;
  localparam int DEPTH = 4;
  typedef logic [68:0] bundle_t;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] instruction = '0;
  logic in_ready, out_valid, reg_wr, pc_wr, mem_to_reg, alu_src, dm_wr, reg_dst, pc_src, link, illegal;
  logic [2:0] alu_op;
  logic [4:0] rs, rt, wr_reg;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [15:0] stall_cnt;
  bundle_t obs;
  bundle_t sb[$];
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  decode_stage #(.DEPTH(DEPTH), .REG_W(5), .HAZARD_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .reg_wr(reg_wr), .pc_wr(pc_wr),
    .mem_to_reg(mem_to_reg), .alu_src(alu_src), .dm_wr(dm_wr), .reg_dst(reg_dst), .pc_src(pc_src),
    .link(link), .alu_op(alu_op), .rs(rs), .rt(rt), .wr_reg(wr_reg), .imm16(imm16), .imm26(imm26),
    .illegal(illegal), .stall_cnt(stall_cnt)
  );
  assign obs = {reg_wr, pc_wr, mem_to_reg, alu_src, dm_wr, reg_dst, pc_src, link, illegal,
                alu_op, rs, rt, wr_reg, imm16, imm26};
  // flags order: reg_wr pc_wr mem_to_reg alu_src dm_wr reg_dst pc_src link illegal
  function automatic bundle_t mk(input logic [8:0] f, input logic [2:0] a, input logic [4:0] s,
                                 input logic [4:0] t, input logic [4:0] w, input logic [15:0] i16,
                                 input logic [25:0] i26);
    return {f, a, s, t, w, i16, i26};
  endfunction
  task automatic chk(input string tag, input bundle_t got, input bundle_t exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h required %h", tag, got, exp);
    end
  endtask
  // every accepted output bundle is checked against the oldest expected entry
  always @(negedge clk)
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_out: got %h required none", obs);
      end else begin
        bundle_t e;
        e = sb.pop_front();
        chk("bundle", obs, e);
      end
    end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] w, input bundle_t e, output bit acc);
    in_valid = 1'b1;
    instruction = w;
    acc = in_ready;
    @(posedge clk);
    if (acc) sb.push_back(e);
    #1;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", bundle_t'(sb.size()), '0);
    cyc(2);
  endtask
  task automatic pair(input logic [31:0] w1, input bundle_t e1, input logic [31:0] w2,
                      input bundle_t e2, input logic [2:0] pat, input string tag);
    bit a;
    logic [2:0] seen;
    push(w1, e1, a);
    push(w2, e2, a);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      seen[2-k] = out_valid;
    end
    chk(tag, bundle_t'(seen), bundle_t'(pat));
    drain();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end
  initial begin
    bit a;
    int acc_cnt;
    bundle_t snap;
    logic [31:0] words [14];
    bundle_t exps [14];
    bundle_t e_lw8;
    e_lw8 = mk(9'b101100000, 3'd0, 5'd9, 5'd0, 5'd8, 16'd4, 26'd0);
    words = '{32'h0CABCDEF, 32'hFC000000, 32'h00221822, 32'h0022182A, 32'h00221826, 32'h00221821,
              32'h2610AAAA, 32'h03E00008, 32'h38C51234, 32'hACC70008, 32'h10220010, 32'h14220010,
              32'h08123456, 32'h0022183F};
    exps = '{mk(9'b100000110, 3'd0, 5'd0, 5'd0, 5'd31, 16'h0, 26'h0ABCDEF),
             mk(9'b000000001, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0),
             mk(9'b100000000, 3'd1, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0),
             mk(9'b100000000, 3'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0),
             mk(9'b100000000, 3'd3, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0),
             mk(9'b100000000, 3'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0),
             mk(9'b100101000, 3'd0, 5'd16, 5'd0, 5'd16, 16'hAAAA, 26'h0),
             mk(9'b010000000, 3'd0, 5'd31, 5'd0, 5'd0, 16'h0, 26'h0),
             mk(9'b100101000, 3'd3, 5'd6, 5'd0, 5'd5, 16'h1234, 26'h0),
             mk(9'b000110000, 3'd0, 5'd6, 5'd7, 5'd0, 16'h0008, 26'h0),
             mk(9'b000000100, 3'd1, 5'd1, 5'd2, 5'd0, 16'h0010, 26'h0),
             mk(9'b000000100, 3'd4, 5'd1, 5'd2, 5'd0, 16'h0010, 26'h0),
             mk(9'b000000100, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0123456),
             mk(9'b000000001, 3'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0)};
    cyc(2);
    rst_n = 1'b1;
    chk("rst_out_valid", bundle_t'(out_valid), '0);
    chk("rst_in_ready", bundle_t'(in_ready), bundle_t'(1));
    chk("rst_bundle", obs, '0);
    chk("rst_stall_cnt", bundle_t'(stall_cnt), '0);
    out_ready = 1'b1;
    push(32'h2210AAAA, mk(9'b100101000, 3'd0, 5'd16, 5'd0, 5'd16, 16'hAAAA, 26'h0), a);
    in_valid = 1'b0;
    chk("latency_edge1", bundle_t'(out_valid), '0);
    cyc(1);
    chk("latency_edge2", bundle_t'(out_valid), bundle_t'(1));
    drain();
    pair(32'h8D280004, e_lw8, 32'h010B5020,
         mk(9'b100000000, 3'd0, 5'd8, 5'd11, 5'd10, 16'h0, 26'h0), 3'b101, "lu_bubble");
    chk("stall_cnt_1", bundle_t'(stall_cnt), bundle_t'(1));
    pair(32'h8D200004, mk(9'b101100000, 3'd0, 5'd9, 5'd0, 5'd0, 16'd4, 26'd0), 32'h000B5020,
         mk(9'b100000000, 3'd0, 5'd0, 5'd11, 5'd10, 16'h0, 26'h0), 3'b110, "lw_r0_no_bubble");
    chk("stall_cnt_r0", bundle_t'(stall_cnt), bundle_t'(1));
    pair(32'h8D280004, e_lw8, 32'hAD280000,
         mk(9'b000110000, 3'd0, 5'd9, 5'd8, 5'd0, 16'h0, 26'h0), 3'b101, "lu_sw_rt");
    chk("stall_cnt_2", bundle_t'(stall_cnt), bundle_t'(2));
    pair(32'h8D280004, e_lw8, 32'h21280001,
         mk(9'b100101000, 3'd0, 5'd9, 5'd0, 5'd8, 16'h1, 26'h0), 3'b110, "addi_rt_not_read");
    chk("stall_cnt_still_2", bundle_t'(stall_cnt), bundle_t'(2));
    for (int i = 0; i < 14; i++) push(words[i], exps[i], a);
    in_valid = 1'b0;
    drain();
    out_ready = 1'b0;
    acc_cnt = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      push(32'h22100000 | i, mk(9'b100101000, 3'd0, 5'd16, 5'd0, 5'd16, 16'(i), 26'h0), a);
      acc_cnt += int'(a);
    end
    in_valid = 1'b0;
    chk("full_accepted", bundle_t'(acc_cnt), bundle_t'(DEPTH + 1));
    chk("full_in_ready", bundle_t'(in_ready), '0);
    chk("full_out_valid", bundle_t'(out_valid), bundle_t'(1));
    snap = obs;
    cyc(3);
    chk("hold_bundle", obs, snap);
    chk("hold_valid", bundle_t'(out_valid), bundle_t'(1));
    out_ready = 1'b1;
    drain();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h38C50000 | i, '0, a);
    in_valid = 1'b1;
    instruction = 32'h2210BEEF;
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    chk("flush_out_valid", bundle_t'(out_valid), '0);
    chk("flush_in_ready", bundle_t'(in_ready), bundle_t'(1));
    chk("flush_stall_cnt", bundle_t'(stall_cnt), bundle_t'(2));
    out_ready = 1'b1;
    cyc(4);
    chk("flush_empty", bundle_t'(out_valid), '0);
    push(32'h38C51234, exps[8], a);
    in_valid = 1'b0;
    drain();
    out_ready = 1'b0;
    push(32'h8D280004, e_lw8, a);
    push(32'h010B5020, '0, a);
    in_valid = 1'b0;
    cyc(1);
    chk("pre_reset_valid", bundle_t'(out_valid), bundle_t'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", bundle_t'(out_valid), '0);
    chk("async_bundle", obs, '0);
    chk("async_stall_cnt", bundle_t'(stall_cnt), '0);
    sb.delete();
    cyc(1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    push(32'h0CABCDEF, exps[0], a);
    in_valid = 1'b0;
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipelined, parametrised successor to the single-cycle combinational instruction decoder.
- Buffers fetched 32-bit MIPS instructions in a DEPTH-entry FIFO and decodes the head into a registered control bundle.
- Uses valid/ready handshakes on both sides, detects load-use hazards and inserts bubbles, flags illegal encodings, and supports flush on redirect.
- Sits between fetch and register-read/execute in the pipelined CPU.

Parameters:
- DEPTH, 4, input FIFO entries; power of 2, at least 2.
- REG_W, 5, register index width.
- HAZARD_EN, 1, when 1 load-use bubble insertion is enabled; when 0 no stalls are generated.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch presents instruction.
- in_ready  out  1  FIFO not full.
- instruction  in  32  instruction word.
- flush  in  1  discard FIFO contents and output register.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts bundle.
- reg_wr, pc_wr, mem_to_reg, alu_src, dm_wr, reg_dst, pc_src, link  out  1 each  control flags.
- alu_op  out  3  ALU operation: 0 add, 1 sub, 2 slt, 3 xor, 4 bne-compare.
- rs, rt, wr_reg  out  REG_W  source registers and final destination register.
- imm16  out  16  immediate field.
- imm26  out  26  jump target field.
- illegal  out  1  unrecognised opcode or funct.
- stall_cnt  out  16  saturating count of inserted bubbles.

Behaviour:
- Reset (asynchronous, rst_n low): FIFO empty, out_valid=0, all control outputs 0, stall_cnt=0. in_ready=1 on the first cycle after rst_n rises.
- Push: occurs when in_valid && in_ready. Pop: occurs when the FIFO is non-empty, the output register is free (!out_valid || out_ready) and no hazard is active.
- Latency: an instruction pushed on edge k appears with out_valid=1 after edge k+1 at the earliest. There is no combinational bypass.
- Full FIFO: in_ready=0 and the word is not stored. Simultaneous push and pop on a full FIFO is not allowed, because in_ready is already 0. Pointers wrap modulo DEPTH, with an extra bit to distinguish full from empty.
- Decode opcode 0, R-type:
  - funct 0x20/0x21 (add, addu): alu_op 0.
  - funct 0x22 (sub): alu_op 1.
  - funct 0x2A (slt): alu_op 2.
  - funct 0x26 (xor): alu_op 3.
  - All of these set reg_wr=1 and wr_reg=rd.
  - funct 0x08 (jr): pc_wr=1, reg_wr=0.
  - Any other funct sets illegal.
- Decode other opcodes:
  - addi/addiu (0x08/0x09): alu_src=1, reg_dst=1, reg_wr=1, wr_reg=rt.
  - xori (0x0E): as addi but alu_op 3.
  - lw (0x23): alu_src=1, mem_to_reg=1, reg_wr=1, wr_reg=rt.
  - sw (0x2B): alu_src=1, dm_wr=1.
  - beq (0x04): pc_src=1, alu_op 1.
  - bne (0x05): pc_src=1, alu_op 4.
  - j (0x02): pc_src=1 and imm26.
  - jal (0x03): pc_src=1, link=1, reg_wr=1, wr_reg=31, imm26.
- Fields not used by an instruction are driven 0.
- Illegal encodings: illegal=1, all write enables 0 (reg_wr, dm_wr, pc_wr), and out_valid still asserts so the exception path can observe it.
- Output hold: when out_valid && !out_ready, every output stays stable.
- Load-use hazard (HAZARD_EN=1):
  - Condition: the bundle held in the output register is a lw with wr_reg≠0 and is being accepted this cycle, and the FIFO head reads that register. A read means head rs matches for any instruction, or head rt matches for R-type, sw, beq or bne.
  - Response: no pop; the output register loads a bubble (out_valid=0) for exactly one cycle; stall_cnt increments, saturating at 0xFFFF.
  - On the next cycle the head pops normally.
- Register 0 never causes a hazard.
- Flush: synchronous. The next edge empties the FIFO, clears out_valid and drops any pending hazard. Flush has priority over a simultaneous push (the push is dropped) and over a pop. stall_cnt is unaffected.
- Reset mid-operation: immediately returns to the reset state. Partially buffered instructions are lost.

Decomposition:
- Package decode_pkg holds:
  - opcode and funct localparams;
  - alu_op encodings;
  - the control-bundle struct-equivalent field widths;
  - constant 31 for the link register.
- Sub-module decode_fifo (parametrised DEPTH, 32-bit) holds the buffering.
- A pure combinational decode function or always block lives in decode_stage.

Test Plan:
- Reset, then push addi $16,$16,0xAAAA (0x2210AAAA) → out_valid after 2 edges; alu_src=1, reg_wr=1, wr_reg=16, imm16=0xAAAA, illegal=0.
- Push lw $8,4($9) then add $10,$8,$11 with out_ready=1 → one cycle out_valid=0 between the bundles; stall_cnt=1. Repeat with lw $0 → no bubble.
- Hold out_ready=0 and push DEPTH+2 words → in_ready falls after DEPTH+1 accepted words (FIFO plus output register); outputs stable; release → words emerge in order with none lost or duplicated.
- Push jal 0x0ABCDEF → link=1, reg_wr=1, wr_reg=31, imm26=0x0ABCDEF. Push opcode 0x3F → illegal=1 and all write enables 0.
- Fill FIFO to 3 entries, assert flush together with in_valid → next cycle out_valid=0, FIFO empty, pushed word absent from later output.
- Deassert rst_n asynchronously mid-stream → outputs 0 immediately with no clock edge; stall_cnt=0.
